// File: rtl/slv_i2c_core_if.sv
// Bus bundle for slv_i2c_core: pad-side SCL/SDA, user ACK decision and
// the captured protocol fields handed to user register logic.
interface slv_i2c_core_if #(
  parameter int unsigned DATA_SZ = 8
);
  logic               I_SCL;
  logic               I_SDA;
  logic               I_ACK;
  logic [DATA_SZ-2:0] O_ADDR_SLV;
  logic               O_RW;
  logic [DATA_SZ-1:0] O_ADDR_REG;
  logic [DATA_SZ-1:0] O_DATA_RD;
  logic               O_ACK_MSTR;
  logic               O_SDA;

  modport slave (
    input  I_SCL, I_SDA, I_ACK,
    output O_ADDR_SLV, O_RW, O_ADDR_REG, O_DATA_RD, O_ACK_MSTR, O_SDA
  );

  modport master (
    output I_SCL, I_SDA, I_ACK,
    input  O_ADDR_SLV, O_RW, O_ADDR_REG, O_DATA_RD, O_ACK_MSTR, O_SDA
  );
endinterface

// File: rtl/slv_i2c_core.sv
// Byte-level I2C slave: pad synchronizer, mid-phase strobe generator and
// protocol FSM capturing slave address, R/W, register address and write
// data, and driving the open-drain SDA enable (1 = release, 0 = pull low).
// Optional: define I2C_GLITCH_FILTER_EN to add a 3-sample majority filter
// on SCL/SDA after synchronization (+2 cycles latency).
module slv_i2c_core #(
  parameter int unsigned FPGA_CLK = 50_000_000,
  parameter int unsigned I2C_CLK  = 100_000,
  parameter int unsigned DATA_SZ  = 8
) (
  input  logic          CLK,
  input  logic          RST_n,
  slv_i2c_core_if.slave bus
);

  localparam int unsigned Q       = FPGA_CLK / (4 * I2C_CLK);
  localparam int unsigned CNT_MAX = Q + 1;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned BIT_W   = $clog2(DATA_SZ + 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ACK_ADDR,
    S_REG,
    S_ACK_REG,
    S_WR_DATA,
    S_ACK_WR,
    S_RD_DATA,
    S_RD_ACK,
    S_WAIT_STOP
  } state_t;

  // synchronizer / filter
  logic r_scl_cur, r_sda_cur;
  logic r_scl_prev, r_sda_prev;
  logic w_scl, w_sda;
  logic w_scl_rise, w_scl_fall, w_sda_rise, w_sda_fall;

  // strobes
  logic [CNT_W-1:0] r_cnt;
  logic             w_mid_high, w_mid_low;
  logic             w_start, w_stop;

  // FSM state and registered outputs
  state_t             r_state;
  logic [BIT_W-1:0]   r_bit_cnt;
  logic [DATA_SZ-1:0] r_shift;
  logic               r_ack_slot;
  logic               r_ack_ok;
  logic [DATA_SZ-2:0] r_addr_slv;
  logic               r_rw;
  logic [DATA_SZ-1:0] r_addr_reg;
  logic [DATA_SZ-1:0] r_data_rd;
  logic               r_ack_mstr;
  logic               r_sda;

  logic [DATA_SZ-1:0] w_rx_byte;
  logic               w_last_bit;
  logic               w_rx_state;

  // Pad synchronizer; prev holds the previous level seen by edge detection
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_scl_cur  <= 1'b0;
      r_sda_cur  <= 1'b0;
      r_scl_prev <= 1'b0;
      r_sda_prev <= 1'b0;
    end else begin
      r_scl_cur  <= bus.I_SCL;
      r_sda_cur  <= bus.I_SDA;
      r_scl_prev <= w_scl;
      r_sda_prev <= w_sda;
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  logic [1:0] r_scl_hist, r_sda_hist;
  logic       r_scl_flt, r_sda_flt;

  // Majority vote over the current and two previous synchronized samples
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_scl_hist <= '0;
      r_sda_hist <= '0;
      r_scl_flt  <= 1'b0;
      r_sda_flt  <= 1'b0;
    end else begin
      r_scl_hist <= {r_scl_hist[0], r_scl_cur};
      r_sda_hist <= {r_sda_hist[0], r_sda_cur};
      r_scl_flt  <= (r_scl_cur & r_scl_hist[0]) | (r_scl_cur & r_scl_hist[1]) |
                    (r_scl_hist[0] & r_scl_hist[1]);
      r_sda_flt  <= (r_sda_cur & r_sda_hist[0]) | (r_sda_cur & r_sda_hist[1]) |
                    (r_sda_hist[0] & r_sda_hist[1]);
    end
  end

  assign w_scl = r_scl_flt;
  assign w_sda = r_sda_flt;
`else
  assign w_scl = r_scl_cur;
  assign w_sda = r_sda_cur;
`endif

  assign w_scl_rise = w_scl & ~r_scl_prev;
  assign w_scl_fall = ~w_scl & r_scl_prev;
  assign w_sda_rise = w_sda & ~r_sda_prev;
  assign w_sda_fall = ~w_sda & r_sda_prev;

  assign w_start = w_sda_fall & w_scl;
  assign w_stop  = w_sda_rise & w_scl;

  // Phase timer: cleared on each SCL edge, saturates past Q
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_cnt <= '0;
    end else if (w_scl_rise || w_scl_fall) begin
      r_cnt <= '0;
    end else if (r_cnt != CNT_W'(CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Masked on edge cycles so a stale count never strobes the new phase
  assign w_mid_high = (r_cnt == CNT_W'(Q)) & w_scl  & ~(w_scl_rise | w_scl_fall);
  assign w_mid_low  = (r_cnt == CNT_W'(Q)) & ~w_scl & ~(w_scl_rise | w_scl_fall);

  assign w_rx_byte  = {r_shift[DATA_SZ-2:0], w_sda};
  assign w_last_bit = (r_bit_cnt == BIT_W'(DATA_SZ - 1));
  assign w_rx_state = (r_state == S_ADDR) || (r_state == S_REG) || (r_state == S_WR_DATA);

  // Protocol FSM; START/STOP override any strobe in the same cycle
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_ack_slot <= 1'b0;
      r_ack_ok   <= 1'b0;
      r_addr_slv <= '0;
      r_rw       <= 1'b0;
      r_addr_reg <= '0;
      r_data_rd  <= '0;
      r_ack_mstr <= 1'b0;
      r_sda      <= 1'b1;
    end else if (w_start) begin
      r_state    <= S_ADDR;
      r_bit_cnt  <= '0;
      r_ack_slot <= 1'b0;
      r_sda      <= 1'b1;
    end else if (w_stop) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= '0;
      r_ack_slot <= 1'b0;
      r_sda      <= 1'b1;
    end else begin
      // Receive states share the MSB-first shifter and bit counter
      if (w_rx_state && w_mid_high) begin
        r_shift   <= w_rx_byte;
        r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + 1'b1;
      end

      case (r_state)
        S_IDLE, S_WAIT_STOP: begin
          r_sda <= 1'b1;
        end

        S_ADDR: begin
          if (w_mid_high && w_last_bit) begin
            r_addr_slv <= w_rx_byte[DATA_SZ-1:1];
            r_rw       <= w_rx_byte[0];
            r_ack_slot <= 1'b0;
            r_state    <= S_ACK_ADDR;
          end
        end

        S_REG: begin
          if (w_mid_high && w_last_bit) begin
            r_addr_reg <= w_rx_byte;
            r_ack_slot <= 1'b0;
            r_state    <= S_ACK_REG;
          end
        end

        S_WR_DATA: begin
          if (w_mid_high && w_last_bit) begin
            r_data_rd  <= w_rx_byte;
            r_ack_slot <= 1'b0;
            r_state    <= S_ACK_WR;
          end
        end

        // First mid_low opens the ACK slot, second one closes it; a read
        // address hands straight over to the first transmit bit.
        S_ACK_ADDR, S_ACK_REG, S_ACK_WR: begin
          if (w_mid_low) begin
            if (!r_ack_slot) begin
              r_ack_slot <= 1'b1;
              r_ack_ok   <= bus.I_ACK;
              r_sda      <= ~bus.I_ACK;
            end else begin
              r_ack_slot <= 1'b0;
              r_sda      <= 1'b1;
              if (!r_ack_ok) begin
                r_state <= S_WAIT_STOP;
              end else if (r_state == S_ACK_ADDR && r_rw) begin
                r_sda     <= r_data_rd[DATA_SZ-1];
                r_shift   <= {r_data_rd[DATA_SZ-2:0], 1'b0};
                r_bit_cnt <= BIT_W'(1);
                r_state   <= S_RD_DATA;
              end else if (r_state == S_ACK_ADDR) begin
                r_state <= S_REG;
              end else begin
                r_state <= S_WR_DATA;
              end
            end
          end
        end

        // r_bit_cnt counts bits already put on the bus
        S_RD_DATA: begin
          if (w_mid_low) begin
            if (r_bit_cnt == BIT_W'(DATA_SZ)) begin
              r_sda     <= 1'b1;
              r_bit_cnt <= '0;
              r_state   <= S_RD_ACK;
            end else begin
              r_sda     <= r_shift[DATA_SZ-1];
              r_shift   <= {r_shift[DATA_SZ-2:0], 1'b0};
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end

        S_RD_ACK: begin
          if (w_mid_high) begin
            r_ack_mstr <= ~w_sda;
            if (!w_sda) begin
              r_shift   <= r_data_rd;
              r_bit_cnt <= '0;
              r_state   <= S_RD_DATA;
            end else begin
              r_state <= S_WAIT_STOP;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_sda   <= 1'b1;
        end
      endcase
    end
  end

  assign bus.O_ADDR_SLV = r_addr_slv;
  assign bus.O_RW       = r_rw;
  assign bus.O_ADDR_REG = r_addr_reg;
  assign bus.O_DATA_RD  = r_data_rd;
  assign bus.O_ACK_MSTR = r_ack_mstr;
  assign bus.O_SDA      = r_sda;

endmodule

// File: tb/tb_slv_i2c_core.sv
// Bench for slv_i2c_core: acts as I2C master with an open-drain bus,
// compares captured fields and bus behaviour with a transaction-level model.
module tb_slv_i2c_core;

  localparam int unsigned FPGA_CLK = 4_000_000;
  localparam int unsigned I2C_CLK  = 100_000;
  localparam int unsigned DATA_SZ  = 8;
  localparam int          PH       = 24;

  logic CLK = 1'b0;
  logic RST_n;
  logic m_scl, m_sda, m_ack;
  logic w_bus_sda;

  int n_tests = 0;
  int n_fail  = 0;

  // transaction-level model of the captured fields
  logic [6:0] e_slv;
  logic       e_rw;
  logic [7:0] e_reg;
  logic [7:0] e_data;
  logic       e_ackm;
  bit         alive;

  slv_i2c_core_if #(.DATA_SZ(DATA_SZ)) bus ();

  assign bus.I_SCL = m_scl;
  assign bus.I_SDA = w_bus_sda;
  assign bus.I_ACK = m_ack;
  assign w_bus_sda = m_sda & bus.O_SDA;

  slv_i2c_core #(
    .FPGA_CLK(FPGA_CLK),
    .I2C_CLK (I2C_CLK),
    .DATA_SZ (DATA_SZ)
  ) dut (
    .CLK  (CLK),
    .RST_n(RST_n),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic chk_caps();
    chk("addr_slv", 32'(bus.O_ADDR_SLV), 32'(e_slv));
    chk("rw",       32'(bus.O_RW),       32'(e_rw));
    chk("addr_reg", 32'(bus.O_ADDR_REG), 32'(e_reg));
    chk("data_rd",  32'(bus.O_DATA_RD),  32'(e_data));
    chk("ack_mstr", 32'(bus.O_ACK_MSTR), 32'(e_ackm));
  endtask

  task automatic model_reset();
    e_slv = '0; e_rw = 1'b0; e_reg = '0; e_data = '0; e_ackm = 1'b0; alive = 1'b0;
  endtask

  // One SCL clock: data set early in the low phase, bus sampled early and late in high
  task automatic bit_cycle(input logic b, output logic e, output logic l);
    m_scl = 1'b0;
    cyc(2);
    m_sda = b;
    cyc(PH - 2);
    m_scl = 1'b1;
    cyc(4);
    e = w_bus_sda;
    cyc(PH - 8);
    l = w_bus_sda;
    cyc(4);
  endtask

  task automatic m_start();
    m_scl = 1'b0;
    cyc(2);
    m_sda = 1'b1;
    cyc(PH - 2);
    m_scl = 1'b1;
    cyc(PH);
    m_sda = 1'b0;
    cyc(PH);
    alive = 1'b1;
  endtask

  task automatic m_stop();
    m_scl = 1'b0;
    cyc(2);
    m_sda = 1'b0;
    cyc(PH - 2);
    m_scl = 1'b1;
    cyc(PH);
    m_sda = 1'b1;
    cyc(PH);
    alive = 1'b0;
    chk("sda_after_stop", 32'(bus.O_SDA), 32'd1);
    chk_caps();
  endtask

  // kind: 0 = address byte, 1 = register byte, 2 = data byte
  task automatic w_byte(input logic [7:0] b, input logic k, input int kind);
    logic e, l;
    logic exp_ack;
    m_ack = k;
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], e, l);
    bit_cycle(1'b1, e, l);
    exp_ack = alive & k;
    chk("ack_whole_high", 32'(!e && !l), 32'(exp_ack));
    chk("ack_any_low",    32'(!e || !l), 32'(exp_ack));
    if (alive) begin
      case (kind)
        0:       begin e_slv = b[7:1]; e_rw = b[0]; end
        1:       e_reg = b;
        default: e_data = b;
      endcase
    end
    alive = alive & k;
    chk_caps();
  endtask

  task automatic r_byte(input logic mack);
    logic e, l;
    logic [7:0] d;
    logic [7:0] exp_d;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, e, l);
      d[i] = l;
    end
    bit_cycle(~mack, e, l);
    exp_d = alive ? e_data : 8'hFF;
    chk("rd_byte", 32'(d), 32'(exp_d));
    if (alive) e_ackm = mack;
    alive = alive & mack;
    chk_caps();
  endtask

  initial begin
    logic e, l;
    logic [7:0] a;
    int nd;
    model_reset();
    m_scl = 1'b1;
    m_sda = 1'b1;
    m_ack = 1'b1;
    RST_n = 1'b0;
    cyc(5);
    chk("rst_sda", 32'(bus.O_SDA), 32'd1);
    chk_caps();
    RST_n = 1'b1;
    cyc(10);

    // write 0xA4 / 0x10 / 0x5A
    m_start();
    w_byte(8'hA4, 1'b1, 0);
    w_byte(8'h10, 1'b1, 1);
    w_byte(8'h5A, 1'b1, 2);
    m_stop();

    // read the same byte twice, ACK then NACK; further clocks see a released bus
    m_start();
    w_byte(8'hA5, 1'b1, 0);
    r_byte(1'b1);
    r_byte(1'b0);
    r_byte(1'b0);
    m_stop();

    // user NACK on the address: rest of the transfer ignored
    m_start();
    w_byte(8'hA4, 1'b0, 0);
    w_byte(8'h77, 1'b1, 1);
    w_byte(8'h88, 1'b1, 2);
    m_stop();

    // repeated START after the register byte
    m_start();
    w_byte(8'hA4, 1'b1, 0);
    w_byte(8'h33, 1'b1, 1);
    m_start();
    w_byte(8'hA5, 1'b1, 0);
    r_byte(1'b0);
    m_stop();

    // reset while the slave is holding the ACK low
    m_start();
    m_ack = 1'b1;
    a = 8'hA4;
    for (int i = 7; i >= 0; i--) bit_cycle(a[i], e, l);
    m_scl = 1'b0;
    cyc(2);
    m_sda = 1'b1;
    cyc(PH - 4);
    chk("ack_before_rst", 32'(bus.O_SDA), 32'd0);
    RST_n = 1'b0;
    cyc(1);
    model_reset();
    chk("rst_mid_sda", 32'(bus.O_SDA), 32'd1);
    chk_caps();
    cyc(3);
    RST_n = 1'b1;
    m_scl = 1'b1;
    m_sda = 1'b1;
    cyc(PH);
    w_byte(8'hA4, 1'b1, 0);
    w_byte(8'h12, 1'b1, 1);
    m_stop();

    // randomized transactions
    for (int t = 0; t < 12; t++) begin
      a = {7'($urandom), 1'($urandom)};
      m_start();
      w_byte(a, 1'(($urandom % 5) != 0), 0);
      if (!a[0]) begin
        w_byte(8'($urandom), 1'(($urandom % 5) != 0), 1);
        nd = int'($urandom % 3);
        for (int j = 0; j < nd; j++) w_byte(8'($urandom), 1'(($urandom % 5) != 0), 2);
      end else begin
        nd = 1 + int'($urandom % 2);
        for (int j = 0; j < nd; j++) r_byte(1'(j < nd - 1));
      end
      m_stop();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
